// File: rtl/octal_ram_pkg.sv
// Shared types and constants for the Octal RAM init sequencer: FSM states,
// error codes, mode-register addresses and the masked readback compare.
package octal_ram_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    ST_PWRUP,
    ST_LOAD,
    ST_ISSUE,
    ST_WAIT_RSP,
    ST_NEXT,
    ST_RETRY,
    ST_DONE,
    ST_FAIL
  } state_t;

  localparam logic [1:0] ERR_NONE      = 2'b00;
  localparam logic [1:0] ERR_ISSUE_TMO = 2'b01;
  localparam logic [1:0] ERR_RSP_TMO   = 2'b10;
  localparam logic [1:0] ERR_MISMATCH  = 2'b11;

  localparam logic [DATA_W-1:0] MA0 = 8'h00;
  localparam logic [DATA_W-1:0] MA4 = 8'h04;
  localparam logic [DATA_W-1:0] MA6 = 8'h06;
  localparam logic [DATA_W-1:0] MA8 = 8'h08;

  function automatic logic masked_neq(input logic [DATA_W-1:0] a,
                                      input logic [DATA_W-1:0] b,
                                      input logic [DATA_W-1:0] mask);
    return ((a ^ b) & mask) != '0;
  endfunction

endpackage

// File: rtl/octal_ram_shadow_cmp.sv
// Shadow copy of the mode-register writes the sequencer has issued, with a
// lookup port that compares a readback against the most recent matching write.
module octal_ram_shadow_cmp
  import octal_ram_pkg::*;
#(
  parameter int               NUM_WR   = 4,
  parameter logic [DATA_W-1:0] CMP_MASK = 8'hFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_idx,
  input  logic [DATA_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0] lk_addr,
  input  logic [DATA_W-1:0] lk_data,
  output logic              hit,
  output logic              mismatch
);

  logic [NUM_WR-1:0] vld_q;
  logic [DATA_W-1:0] addr_q [NUM_WR];
  logic [DATA_W-1:0] data_q [NUM_WR];

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      vld_q <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < NUM_WR; i++) begin
        if (wr_idx == DATA_W'(i)) vld_q[i] <= 1'b1;
      end
    end
  end

  // NOTE: only the valid bits are reset; addr/data are never read unless the
  // slot is valid, so the storage array itself needs no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < NUM_WR; i++) begin
        if (wr_idx == DATA_W'(i)) begin
          addr_q[i] <= wr_addr;
          data_q[i] <= wr_data;
        end
      end
    end
  end

  // Ascending scan: a later slot with the same address overrides earlier ones.
  always_comb begin
    hit      = 1'b0;
    mismatch = 1'b0;
    for (int i = 0; i < NUM_WR; i++) begin
      if (vld_q[i] && addr_q[i] == lk_addr) begin
        hit      = 1'b1;
        mismatch = masked_neq(lk_data, data_q[i], CMP_MASK);
      end
    end
  end

endmodule

// File: rtl/octal_ram_init_seq.sv
// Power-up / re-init sequencer: walks the MR config table (writes then reads),
// verifies readbacks against the shadow of issued writes and retries on error.
module octal_ram_init_seq
  import octal_ram_pkg::*;
#(
  parameter int               NUM_WR         = 4,
  parameter int               NUM_RD         = 6,
  parameter int               PWRUP_CYCLES   = 20000,
  parameter int               TIMEOUT_CYCLES = 255,
  parameter int               MAX_RETRY      = 2,
  parameter logic [DATA_W-1:0] CMP_MASK       = 8'hFF
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iStart,
  output logic [DATA_W-1:0] oCfgNo,
  input  logic [DATA_W-1:0] iRegAddr,
  input  logic [DATA_W-1:0] iRegData,
  output logic              oCmdValid,
  output logic              oCmdWr,
  output logic [DATA_W-1:0] oCmdAddr,
  output logic [DATA_W-1:0] oCmdData,
  input  logic              iCmdReady,
  input  logic              iRspValid,
  input  logic [DATA_W-1:0] iRspData,
  output logic              oLogValid,
  output logic [DATA_W-1:0] oLogAddr,
  output logic [DATA_W-1:0] oLogData,
  output logic              oBusy,
  output logic              oDone,
  output logic              oFail,
  output logic [1:0]        oErrCode,
  output logic [1:0]        oRetryCnt
);

  localparam int PWR_W = $clog2(PWRUP_CYCLES + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [PWR_W-1:0]  PWR_LAST = PWR_W'(PWRUP_CYCLES - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [DATA_W-1:0] CFG_LAST = DATA_W'(NUM_WR + NUM_RD - 1);

  state_t            state_q, state_d;
  logic [PWR_W-1:0]  pwrup_cnt;
  logic [TMO_W-1:0]  tmo_cnt;
  logic              cmd_acc, rsp_take, err_hit;
  logic [1:0]        err_d;
  logic              is_wr, cfg_last;
  logic              sh_clr, sh_hit, sh_miss;

  assign is_wr    = oCfgNo < DATA_W'(NUM_WR);
  assign cfg_last = oCfgNo == CFG_LAST;

  // NOTE: every signal written in always_comb is given a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    cmd_acc  = 1'b0;
    rsp_take = 1'b0;
    err_hit  = 1'b0;
    err_d    = ERR_NONE;
    unique case (state_q)
      ST_PWRUP:   if (pwrup_cnt == PWR_LAST) state_d = ST_LOAD;
      ST_LOAD:    state_d = ST_ISSUE;
      ST_ISSUE: begin
        if (iCmdReady) begin
          cmd_acc = 1'b1;
          state_d = oCmdWr ? ST_NEXT : ST_WAIT_RSP;
        end else if (tmo_cnt == TMO_LAST) begin
          err_hit = 1'b1;
          err_d   = ERR_ISSUE_TMO;
        end
      end
      // A response arriving on the expiry cycle is taken, not timed out.
      ST_WAIT_RSP: begin
        if (iRspValid) begin
          rsp_take = 1'b1;
          if (sh_hit && sh_miss) begin
            err_hit = 1'b1;
            err_d   = ERR_MISMATCH;
          end else begin
            state_d = ST_NEXT;
          end
        end else if (tmo_cnt == TMO_LAST) begin
          err_hit = 1'b1;
          err_d   = ERR_RSP_TMO;
        end
      end
      ST_NEXT:    state_d = cfg_last ? ST_DONE : ST_LOAD;
      ST_RETRY:   state_d = ST_LOAD;
      ST_DONE,
      ST_FAIL:    if (iStart) state_d = ST_LOAD;
      default:    state_d = ST_PWRUP;
    endcase
    if (err_hit) state_d = (int'(oRetryCnt) < MAX_RETRY) ? ST_RETRY : ST_FAIL;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge iClk) begin
    if (iRst) state_q <= ST_PWRUP;
    else      state_q <= state_d;
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      pwrup_cnt <= '0;
      tmo_cnt   <= '0;
      oCfgNo    <= '0;
      oCmdWr    <= 1'b0;
      oCmdAddr  <= '0;
      oCmdData  <= '0;
      oLogValid <= 1'b0;
      oLogAddr  <= '0;
      oLogData  <= '0;
      oErrCode  <= ERR_NONE;
      oRetryCnt <= '0;
    end else begin
      oLogValid <= 1'b0;
      unique case (state_q)
        ST_PWRUP: if (pwrup_cnt != PWR_LAST) pwrup_cnt <= pwrup_cnt + 1'b1;
        ST_LOAD: begin
          oCmdAddr <= iRegAddr;
          oCmdData <= is_wr ? iRegData : '0;
          oCmdWr   <= is_wr;
          tmo_cnt  <= '0;
        end
        ST_ISSUE,
        ST_WAIT_RSP: tmo_cnt <= cmd_acc ? '0 : tmo_cnt + 1'b1;
        ST_NEXT:  if (!cfg_last) oCfgNo <= oCfgNo + 1'b1;
        ST_RETRY: begin
          oRetryCnt <= oRetryCnt + 1'b1;
          oCfgNo    <= '0;
        end
        ST_DONE,
        ST_FAIL: begin
          if (iStart) begin
            oErrCode  <= ERR_NONE;
            oRetryCnt <= '0;
            oCfgNo    <= '0;
          end
        end
        default: ;
      endcase
      if (rsp_take) begin
        oLogValid <= 1'b1;
        oLogAddr  <= oCmdAddr;
        oLogData  <= iRspData;
      end
      if (err_hit) oErrCode <= err_d;
    end
  end

  assign oCmdValid = state_q == ST_ISSUE;
  assign oDone     = state_q == ST_DONE;
  assign oFail     = state_q == ST_FAIL;
  assign oBusy     = !(oDone || oFail);

  assign sh_clr = (state_q == ST_RETRY) || ((oDone || oFail) && iStart);

  octal_ram_shadow_cmp #(
    .NUM_WR   (NUM_WR),
    .CMP_MASK (CMP_MASK)
  ) u_shadow (
    .clk      (iClk),
    .rst      (iRst),
    .clr      (sh_clr),
    .wr_en    (cmd_acc && oCmdWr),
    .wr_idx   (oCfgNo),
    .wr_addr  (oCmdAddr),
    .wr_data  (oCmdData),
    .lk_addr  (oCmdAddr),
    .lk_data  (iRspData),
    .hit      (sh_hit),
    .mismatch (sh_miss)
  );

endmodule

// File: tb/tb_octal_ram_init_seq.sv
// Scoreboard bench for octal_ram_init_seq: a behavioural command engine plus
// directed scenarios for normal run, mismatch, issue/response timeouts, reset and restart.
module tb_octal_ram_init_seq;
  import octal_ram_pkg::*;

  localparam int PWR = 16;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } log_t;

  logic       iClk = 1'b0;
  logic       iRst, iStart, iCmdReady;
  logic [7:0] oCfgNo, iRegAddr, iRegData;
  logic       oCmdValid, oCmdWr;
  logic [7:0] oCmdAddr, oCmdData;
  logic       iRspValid;
  logic [7:0] iRspData;
  logic       oLogValid;
  logic [7:0] oLogAddr, oLogData;
  logic       oBusy, oDone, oFail;
  logic [1:0] oErrCode, oRetryCnt;

  int   n_vec = 0;
  int   n_err = 0;
  log_t exp_q[$];

  logic bad_ma4 = 1'b0;
  logic drop_ma8 = 1'b0;
  int   stray_req = 0;
  int   stray_done = 0;

  always #5 iClk = ~iClk;

  octal_ram_init_seq #(.PWRUP_CYCLES(PWR)) dut (
    .iClk(iClk), .iRst(iRst), .iStart(iStart), .oCfgNo(oCfgNo),
    .iRegAddr(iRegAddr), .iRegData(iRegData),
    .oCmdValid(oCmdValid), .oCmdWr(oCmdWr), .oCmdAddr(oCmdAddr), .oCmdData(oCmdData),
    .iCmdReady(iCmdReady), .iRspValid(iRspValid), .iRspData(iRspData),
    .oLogValid(oLogValid), .oLogAddr(oLogAddr), .oLogData(oLogData),
    .oBusy(oBusy), .oDone(oDone), .oFail(oFail),
    .oErrCode(oErrCode), .oRetryCnt(oRetryCnt)
  );

  // External config table, combinational from the index.
  function automatic logic [15:0] tbl(input logic [7:0] n);
    case (n)
      8'd0:    tbl = {MA0, 8'h28};
      8'd1:    tbl = {MA4, 8'h40};
      8'd2:    tbl = {MA6, 8'hF0};
      8'd3:    tbl = {MA8, 8'h00};
      8'd4:    tbl = {MA0, 8'h00};
      8'd5:    tbl = {8'h01, 8'h00};
      8'd6:    tbl = {8'h02, 8'h00};
      8'd7:    tbl = {8'h03, 8'h00};
      8'd8:    tbl = {MA4, 8'h00};
      8'd9:    tbl = {MA8, 8'h00};
      default: tbl = 16'h0000;
    endcase
  endfunction

  assign {iRegAddr, iRegData} = tbl(oCfgNo);

  // Command engine: accepts when valid&&ready, echoes writes, answers reads 3 cycles later.
  logic [7:0] mr_mem [256];
  int         pend = 0;
  logic [7:0] pend_data = 8'h00;
  initial begin
    for (int i = 0; i < 256; i++) mr_mem[i] = 8'h00;
    mr_mem[1] = 8'h8B;
    mr_mem[2] = 8'h02;
    mr_mem[3] = 8'h30;
    iRspValid = 1'b0;
    iRspData  = 8'h00;
    forever begin
      @(negedge iClk);
      iRspValid = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          iRspValid = 1'b1;
          iRspData  = pend_data;
        end
      end else if (stray_req != stray_done) begin
        iRspValid = 1'b1;
        iRspData  = 8'hEE;
        stray_done++;
      end
      #4;
      if (iRst) begin
        pend = 0;
      end else if (oCmdValid && iCmdReady) begin
        if (oCmdWr) begin
          mr_mem[oCmdAddr] = oCmdData;
        end else if (!(drop_ma8 && oCmdAddr == MA8)) begin
          pend      = 3;
          pend_data = (bad_ma4 && oCmdAddr == MA4) ? 8'h47 : mr_mem[oCmdAddr];
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_status(input string name, input logic busy, input logic done,
                              input logic fail, input logic [1:0] err, input logic [1:0] retry);
    check(name, 32'({oBusy, oDone, oFail, oErrCode, oRetryCnt}),
          32'({busy, done, fail, err, retry}));
  endtask

  task automatic monitor();
    log_t e;
    forever begin
      @(negedge iClk);
      if (oLogValid) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL log_unexpected: got addr=%h data=%h, expected no log", oLogAddr, oLogData);
        end else begin
          e = exp_q.pop_front();
          check("log_entry", 32'({oLogAddr, oLogData}), 32'(e));
        end
      end
    end
  endtask

  task automatic push_run(input logic bad4, input int n_reads);
    log_t r [6];
    r[0] = {MA0, 8'h28};
    r[1] = {8'h01, 8'h8B};
    r[2] = {8'h02, 8'h02};
    r[3] = {8'h03, 8'h30};
    r[4] = {MA4, bad4 ? 8'h47 : 8'h40};
    r[5] = {MA8, 8'h00};
    for (int i = 0; i < n_reads; i++) exp_q.push_back(r[i]);
  endtask

  task automatic pulse_start();
    iStart = 1'b1;
    @(negedge iClk);
    iStart = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output int cyc);
    cyc = 0;
    do begin
      @(negedge iClk);
      cyc++;
    end while (!oCmdValid && cyc < budget);
  endtask

  task automatic wait_end(input int budget);
    int n = 0;
    while (!(oDone || oFail) && n < budget) begin
      @(negedge iClk);
      n++;
    end
    check("end_reached", 32'(oDone || oFail), 32'd1);
    repeat (2) @(negedge iClk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, n, n_hi, n_bad;
    iRst = 1'b1;
    iStart = 1'b0;
    iCmdReady = 1'b1;
    fork
      monitor();
    join_none

    // Reset state
    repeat (3) @(negedge iClk);
    check_status("reset_status", 1'b1, 1'b0, 1'b0, ERR_NONE, 2'd0);
    check("reset_outputs", 32'({oCmdValid, oCmdWr, oCmdAddr, oCmdData, oCfgNo, oLogValid}), 32'd0);

    // Normal sequence; iStart while busy must be ignored
    push_run(1'b0, 6);
    iRst = 1'b0;
    wait_valid(100, cyc);
    check("pwrup_cycles", 32'(cyc), 32'(PWR + 1));
    n = 0;
    while (!oLogValid && n < 300) begin
      @(negedge iClk);
      n++;
    end
    check("first_log_seen", 32'(oLogValid), 32'd1);
    pulse_start();
    wait_end(2000);
    check_status("seq_done", 1'b0, 1'b1, 1'b0, ERR_NONE, 2'd0);
    check("sb_empty_normal", 32'(exp_q.size()), 32'd0);

    // Persistent MA4 corruption: two retries then FAIL
    bad_ma4 = 1'b1;
    for (int k = 0; k < 3; k++) push_run(1'b1, 5);
    pulse_start();
    check_status("start_from_done", 1'b1, 1'b0, 1'b0, ERR_NONE, 2'd0);
    wait_valid(10, cyc);
    check("restart_no_pwrup", 32'(cyc + 1), 32'd2);
    wait_end(3000);
    check_status("mismatch_fail", 1'b0, 1'b0, 1'b1, ERR_MISMATCH, 2'd2);
    check("sb_empty_mismatch", 32'(exp_q.size()), 32'd0);

    // Ready held low on entry 1: issue timeout, then recovery on retry
    bad_ma4 = 1'b0;
    push_run(1'b0, 6);
    pulse_start();
    check_status("start_from_fail", 1'b1, 1'b0, 1'b0, ERR_NONE, 2'd0);
    n = 0;
    while (!(oCfgNo == 8'd1 && !oCmdValid) && n < 100) begin
      @(negedge iClk);
      n++;
    end
    iCmdReady = 1'b0;
    n = 0;
    while (!oCmdValid && n < 10) begin
      @(negedge iClk);
      n++;
    end
    n_hi = 0;
    n_bad = 0;
    while (oCmdValid && n_hi < 400) begin
      if ({oCmdWr, oCmdAddr, oCmdData, oCfgNo} !== {1'b1, MA4, 8'h40, 8'd1}) n_bad++;
      n_hi++;
      @(negedge iClk);
    end
    check("issue_hold_cycles", 32'(n_hi), 32'd255);
    check("issue_cmd_stable", 32'(n_bad), 32'd0);
    @(negedge iClk);
    check_status("issue_tmo", 1'b1, 1'b0, 1'b0, ERR_ISSUE_TMO, 2'd1);
    check("retry_cfg_zero", 32'(oCfgNo), 32'd0);
    iCmdReady = 1'b1;
    wait_end(2000);
    check_status("retry_recovered", 1'b0, 1'b1, 1'b0, ERR_ISSUE_TMO, 2'd1);
    check("sb_empty_issue_tmo", 32'(exp_q.size()), 32'd0);

    // Missing MA8 response, plus a stray response during ISSUE
    drop_ma8 = 1'b1;
    for (int k = 0; k < 3; k++) push_run(1'b0, 5);
    iCmdReady = 1'b0;
    pulse_start();
    wait_valid(10, cyc);
    stray_req++;
    repeat (4) @(negedge iClk);
    check("stray_hold_issue", 32'({oCmdValid, oCfgNo}), 32'({1'b1, 8'd0}));
    iCmdReady = 1'b1;
    wait_end(3000);
    check_status("rsp_tmo_fail", 1'b0, 1'b0, 1'b1, ERR_RSP_TMO, 2'd2);
    check("sb_empty_rsp_tmo", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of ISSUE restarts power-up
    drop_ma8 = 1'b0;
    push_run(1'b0, 6);
    iCmdReady = 1'b0;
    pulse_start();
    wait_valid(10, cyc);
    check("pre_rst_valid", 32'(oCmdValid), 32'd1);
    iRst = 1'b1;
    @(negedge iClk);
    check("rst_mid_issue", 32'({oCmdValid, oBusy, oDone, oFail, oErrCode, oRetryCnt, oCfgNo}),
          32'({1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 8'h00}));
    iRst = 1'b0;
    iCmdReady = 1'b1;
    wait_valid(100, cyc);
    check("pwrup_restart", 32'(cyc), 32'(PWR + 1));
    wait_end(2000);
    check_status("rerun_done", 1'b0, 1'b1, 1'b0, ERR_NONE, 2'd0);
    check("sb_empty_reset", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
